// File: rtl/shift_op_sequencer.sv
`default_nettype none
// ============================================================================
// shift_op_sequencer : FIFO-queued command sequencer for an 8-bit shift register
// Revision 1.0
// ============================================================================
module shift_op_sequencer #(
  parameter int DEPTH = 4
) (
  input  logic       clk,
  input  logic       clrn,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [2:0] cmd_op,
  input  logic [2:0] cmd_cnt,
  input  logic [7:0] cmd_data,
  input  logic [7:0] sr_q,
  output logic [2:0] sr_key,
  output logic [7:0] sr_data,
  output logic       busy,
  output logic       done
);

  localparam int         c_AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [2:0] c_OP_CLEAR = 3'b000;
  localparam logic [2:0] c_OP_SET   = 3'b001;
  localparam logic [2:0] c_OP_SER   = 3'b101;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t        r_state;
  state_t        w_state_nxt;
  logic [13:0]   r_mem [DEPTH];
  logic [c_AW:0] r_wptr;
  logic [c_AW:0] r_rptr;
  logic [2:0]    r_cur_op;
  logic [7:0]    r_cur_data;
  logic [3:0]    r_cnt;
  logic          r_live;

  logic          w_full;
  logic          w_empty;
  logic          w_push;
  logic          w_pop;
  logic [13:0]   w_head;
  logic [2:0]    w_head_op;
  logic [2:0]    w_head_cnt;
  logic [7:0]    w_head_data;
  logic [3:0]    w_load_cnt;
  logic [2:0]    w_bit_idx;

  assign w_full      = (r_wptr[c_AW] != r_rptr[c_AW]) &&
                       (r_wptr[c_AW-1:0] == r_rptr[c_AW-1:0]);
  assign w_empty     = (r_wptr == r_rptr);
  // r_live holds outputs in their reset values until the first edge after clrn rises
  assign cmd_ready   = r_live && !w_full;
  assign w_push      = cmd_valid && cmd_ready;
  assign w_pop       = r_live && (r_state == S_IDLE) && !w_empty;
  assign w_head      = r_mem[r_rptr[c_AW-1:0]];
  assign w_head_op   = w_head[13:11];
  assign w_head_cnt  = w_head[10:8];
  assign w_head_data = w_head[7:0];
  // counter runs 8..1 during a serial load, so the bit index is 8 - count
  assign w_bit_idx   = 3'(4'd8 - r_cnt);

  always_comb begin
    w_load_cnt = (w_head_cnt == 3'd0) ? 4'd8 : {1'b0, w_head_cnt};
    if ((w_head_op == c_OP_CLEAR) || (w_head_op == c_OP_SET)) begin
      w_load_cnt = 4'd1;
    end else if (w_head_op == c_OP_SER) begin
      w_load_cnt = 4'd8;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wptr[c_AW-1:0]] <= {cmd_op, cmd_cnt, cmd_data};
    end
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      r_state    <= S_IDLE;
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_cur_op   <= 3'b000;
      r_cur_data <= 8'h00;
      r_cnt      <= 4'd0;
      r_live     <= 1'b0;
    end else begin
      r_live  <= 1'b1;
      r_state <= w_state_nxt;
      if (w_push) begin
        r_wptr <= r_wptr + 1'b1;
      end
      if (w_pop) begin
        r_rptr     <= r_rptr + 1'b1;
        r_cur_op   <= w_head_op;
        r_cur_data <= w_head_data;
        r_cnt      <= w_load_cnt;
      end else if (r_state == S_EXEC) begin
        r_cnt <= r_cnt - 4'd1;
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    sr_key      = c_OP_SET;
    sr_data     = sr_q;
    busy        = 1'b0;
    done        = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_pop) begin
          w_state_nxt = S_EXEC;
        end
      end
      S_EXEC: begin
        busy   = 1'b1;
        sr_key = r_cur_op;
        case (r_cur_op)
          c_OP_SET: sr_data = r_cur_data;
          c_OP_SER: sr_data = {7'b0, r_cur_data[w_bit_idx]};
          default:  sr_data = 8'h00;
        endcase
        if (r_cnt == 4'd1) begin
          w_state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        busy        = 1'b1;
        done        = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
    // forcing key 000 during reset clears the datapath
    if (!r_live) begin
      sr_key  = c_OP_CLEAR;
      sr_data = 8'h00;
      busy    = 1'b0;
      done    = 1'b0;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_shift_op_sequencer.sv
`default_nettype none
// tb_shift_op_sequencer : random and directed stimulus against a transaction-level
// model of the command queue plus a behavioural shift-register datapath.
module tb_shift_op_sequencer;

  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       clrn = 1'b0;
  logic       cmd_valid = 1'b0;
  logic [2:0] cmd_op = 3'b000;
  logic [2:0] cmd_cnt = 3'b000;
  logic [7:0] cmd_data = 8'h00;
  logic       cmd_ready;
  logic [7:0] sr_q;
  logic [2:0] sr_key;
  logic [7:0] sr_data;
  logic       busy;
  logic       done;
  logic [7:0] dp = 8'h00;

  assign sr_q = dp;

  always #5 clk = ~clk;

  shift_op_sequencer #(.DEPTH(DEPTH)) dut (
    .clk      (clk),
    .clrn     (clrn),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_op   (cmd_op),
    .cmd_cnt  (cmd_cnt),
    .cmd_data (cmd_data),
    .sr_q     (sr_q),
    .sr_key   (sr_key),
    .sr_data  (sr_data),
    .busy     (busy),
    .done     (done)
  );

  function automatic logic [7:0] dp_next(input logic [7:0] q, input logic [2:0] k,
                                         input logic [7:0] d);
    case (k)
      3'd0:    return 8'h00;
      3'd1:    return d;
      3'd2:    return q >> 1;
      3'd3:    return q << 1;
      3'd4:    return {q[7], q[7:1]};
      3'd5:    return {d[0], q[7:1]};
      3'd6:    return {q[0], q[7:1]};
      default: return {q[6:0], q[7]};
    endcase
  endfunction

  always @(posedge clk) dp <= dp_next(dp, sr_key, sr_data);

  typedef struct packed {logic dn; logic [2:0] key; logic [7:0] data;} step_t;
  typedef struct packed {logic [2:0] op; logic [2:0] cnt; logic [7:0] data;} cmd_t;

  cmd_t  m_fifo[$];
  step_t m_sched[$];
  bit    m_live = 1'b0;
  int    total = 0;
  int    bad = 0;
  int    done_cnt = 0;
  int    rol_cycles = 0;
  int    nr_cnt = 0;
  bit    ser_hist[$];

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", nm, got, exp, $time);
    end
  endtask

  // One command becomes its list of per-cycle outputs: N execute steps then a done step.
  function automatic void expand(input cmd_t c);
    int    n;
    step_t s;
    n = (c.op <= 3'd1) ? 1 : (c.op == 3'd5) ? 8 : (c.cnt == 3'd0) ? 8 : int'(c.cnt);
    for (int i = 0; i < n; i++) begin
      s.dn   = 1'b0;
      s.key  = c.op;
      s.data = (c.op == 3'd1) ? c.data : (c.op == 3'd5) ? {7'b0, c.data[i]} : 8'h00;
      m_sched.push_back(s);
    end
    s.dn   = 1'b1;
    s.key  = 3'b001;
    s.data = 8'h00;
    m_sched.push_back(s);
  endfunction

  always @(negedge clk) begin
    logic [2:0] ek;
    logic [7:0] ed;
    logic       eb, edn, er;
    cmd_t       c;
    if (!clrn) begin
      chk("rst_ready", cmd_ready, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_key", sr_key, 0);
      chk("rst_data", sr_data, 0);
      m_fifo.delete();
      m_sched.delete();
      m_live = 1'b0;
    end else begin
      if (!m_live) begin
        ek = 3'd0; ed = 8'h00; eb = 1'b0; edn = 1'b0;
      end else if (m_sched.size() > 0) begin
        eb  = 1'b1;
        edn = m_sched[0].dn;
        ek  = m_sched[0].key;
        ed  = edn ? dp : m_sched[0].data;
      end else begin
        ek = 3'd1; ed = dp; eb = 1'b0; edn = 1'b0;
      end
      er = m_live && (m_fifo.size() < DEPTH);
      chk("ready", cmd_ready, er);
      chk("busy", busy, eb);
      chk("done", done, edn);
      chk("key", sr_key, ek);
      chk("data", sr_data, ed);
      if (done) done_cnt++;
      if (busy && sr_key == 3'b111) rol_cycles++;
      if (busy && sr_key == 3'b101) ser_hist.push_back(sr_data[0]);
      if (m_live && !cmd_ready) nr_cnt++;
      // advance the model across the coming edge
      if (m_live) begin
        if (m_sched.size() > 0) begin
          void'(m_sched.pop_front());
        end else if (m_fifo.size() > 0) begin
          c = m_fifo.pop_front();
          expand(c);
        end
      end
      if (cmd_valid && er) begin
        c.op = cmd_op; c.cnt = cmd_cnt; c.data = cmd_data;
        m_fifo.push_back(c);
      end
      m_live = 1'b1;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [2:0] op, input logic [2:0] cnt, input logic [7:0] d);
    int t;
    bit acc;
    cmd_op = op; cmd_cnt = cnt; cmd_data = d; cmd_valid = 1'b1; t = 0;
    do begin
      acc = cmd_ready;
      tick();
      t++;
    end while (!acc && t < 200);
    if (!acc) chk("push_timeout", acc, 1);
  endtask

  task automatic wait_idle();
    int t;
    t = 0;
    cmd_valid = 1'b0;
    while ((m_fifo.size() != 0 || m_sched.size() != 0) && t < 500) begin
      tick();
      t++;
    end
    if (t >= 500) chk("idle_timeout", t, 0);
    repeat (2) tick();
  endtask

  initial begin
    int base, b2, sb, t;
    logic [7:0] bits;
    repeat (3) @(posedge clk);
    #1 clrn = 1'b1;
    tick();
    chk("post_rst_ready", cmd_ready, 1);
    chk("post_rst_key", sr_key, 3'b001);

    base = done_cnt;
    push(3'd1, 3'd0, 8'hA5);
    wait_idle();
    chk("set_a5_dp", dp, 8'hA5);
    chk("set_a5_done", done_cnt - base, 1);

    push(3'd1, 3'd0, 8'h81);
    wait_idle();
    base = done_cnt; b2 = rol_cycles;
    push(3'd7, 3'd3, 8'hFF);
    wait_idle();
    chk("rol3_dp", dp, 8'h0C);
    chk("rol3_cycles", rol_cycles - b2, 3);
    chk("rol3_done", done_cnt - base, 1);

    sb = ser_hist.size();
    push(3'd5, 3'd2, 8'b1011_0010);
    wait_idle();
    chk("ser_dp", dp, 8'hB2);
    chk("ser_cycles", ser_hist.size() - sb, 8);
    bits = 8'h00;
    for (int i = 0; i < 8; i++) if (sb + i < ser_hist.size()) bits[i] = ser_hist[sb + i];
    chk("ser_bits", bits, 8'hB2);

    base = done_cnt; b2 = nr_cnt;
    push(3'd7, 3'd0, 8'h00);
    push(3'd1, 3'd5, 8'h10);
    push(3'd3, 3'd1, 8'h00);
    push(3'd7, 3'd2, 8'h00);
    push(3'd1, 3'd0, 8'h33);
    push(3'd2, 3'd3, 8'h00);
    wait_idle();
    chk("burst_full_seen", (nr_cnt - b2) > 0, 1);
    chk("burst_done", done_cnt - base, 6);
    chk("burst_dp", dp, 8'h06);

    base = done_cnt; sb = ser_hist.size();
    push(3'd5, 3'd0, 8'h5A);
    push(3'd1, 3'd0, 8'h11);
    push(3'd1, 3'd0, 8'h22);
    cmd_valid = 1'b0;
    t = 0;
    while (!(sr_key == 3'b101 && ser_hist.size() - sb == 4) && t < 100) begin
      tick();
      t++;
    end
    if (t >= 100) chk("ser4_timeout", t, 0);
    clrn = 1'b0;
    #1;
    chk("abort_key_now", sr_key, 3'b000);
    repeat (2) tick();
    clrn = 1'b1;
    repeat (10) tick();
    chk("abort_busy", busy, 0);
    chk("abort_ready", cmd_ready, 1);
    chk("abort_no_done", done_cnt - base, 0);
    chk("abort_dp", dp, 8'h00);

    push(3'd1, 3'd0, 8'h80);
    push(3'd4, 3'd0, 8'h00);
    wait_idle();
    chk("sar_dp", dp, 8'hFF);
    repeat (10) tick();
    chk("sar_hold_dp", dp, 8'hFF);

    for (int i = 0; i < 150; i++) begin
      push(3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)), 8'($urandom_range(0, 255)));
      cmd_valid = 1'b0;
      repeat ($urandom_range(0, 3)) begin
        cmd_op = 3'($urandom); cmd_cnt = 3'($urandom); cmd_data = 8'($urandom);
        tick();
      end
    end
    wait_idle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
